// File: rtl/bus_trace_monitor_if.sv
// bus_trace_monitor_if: snooped CPU bus plus trace drain port for bus_trace_monitor.
// Entry width grows by TS_W when TRACE_TIMESTAMP_EN is defined.
interface bus_trace_monitor_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
);
   localparam int TS_BITS = `ifdef TRACE_TIMESTAMP_EN TS_W `else 0 * TS_W `endif ;
   localparam int ENT_W   = TS_BITS + 4 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic              traceEn;
   logic              trcClr;
   logic              busEn;
   logic              busWe;
   logic [2:0]        strb;
   logic [ADDR_W-1:0] busAddr;
   logic [DATA_W-1:0] busWData;
   logic [DATA_W-1:0] busRData;
   logic              trcValid;
   logic              trcReady;
   logic [ENT_W-1:0]  trcData;
   logic [CNT_W-1:0]  trcCount;
   logic              full;
   logic [15:0]       ovfCnt;

   modport master (
      output traceEn, trcClr, busEn, busWe, strb, busAddr, busWData, busRData, trcReady,
      input  trcValid, trcData, trcCount, full, ovfCnt
   );

   modport slave (
      input  traceEn, trcClr, busEn, busWe, strb, busAddr, busWData, busRData, trcReady,
      output trcValid, trcData, trcCount, full, ovfCnt
   );
endinterface

// File: rtl/bus_trace_monitor.sv
// bus_trace_monitor: snoops the data bus and queues filtered accesses in a show-ahead trace FIFO.
// Optional TRACE_TIMESTAMP_EN prefixes each entry with a free-running cycle count.
module bus_trace_monitor #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 16,
   parameter logic [ADDR_W-1:0] WIN_BASE = '0,
   parameter logic [ADDR_W-1:0] WIN_MASK = '0,
   parameter int                MODE     = 0,
   parameter int                WRAP     = 0,
   parameter int                TS_W     = 16
) (
   input logic                 clk,
   input logic                 reset,
   bus_trace_monitor_if.slave  trc
);
   localparam int TS_BITS = `ifdef TRACE_TIMESTAMP_EN TS_W `else 0 * TS_W `endif ;
   localparam int ENT_W   = TS_BITS + 4 + ADDR_W + DATA_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   logic [ENT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [15:0]       r_ovf;

   logic              w_mode_ok;
   logic              w_win;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_ovf;
   logic              w_wr;
   logic [DATA_W-1:0] w_data;
   logic [ENT_W-1:0]  w_entry;

   always_comb begin
      w_mode_ok = (MODE == 1) ? trc.busWe : (MODE == 2) ? !trc.busWe : 1'b1;
      w_win     = (trc.busAddr & WIN_MASK) == (WIN_BASE & WIN_MASK);
      w_full    = r_count == CNT_W'(DEPTH);
      w_push    = trc.traceEn && trc.busEn && w_win && w_mode_ok && !trc.trcClr;
      w_pop     = (r_count != '0) && trc.trcReady && !trc.trcClr;
      // A push into a full FIFO without a pop is an overflow; WRAP still stores it.
      w_ovf     = w_push && w_full && !w_pop;
      w_wr      = w_push && (!w_full || w_pop || WRAP != 0);
      w_data    = trc.busWe ? trc.busWData : trc.busRData;
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_ts <= '0;
      else        r_ts <= r_ts + TS_W'(1);

   assign w_entry = {r_ts, trc.busWe, trc.strb, trc.busAddr, w_data};
`else
   assign w_entry = {trc.busWe, trc.strb, trc.busAddr, w_data};
`endif

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr] <= w_entry;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= '0;
      end else if (trc.trcClr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop || (w_ovf && WRAP != 0)) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_wr && !w_pop && !w_full) r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push)     r_count <= r_count - CNT_W'(1);
         if (w_ovf && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
      end

   assign trc.trcValid = r_count != '0;
   assign trc.trcData  = r_mem[r_rd_ptr];
   assign trc.trcCount = r_count;
   assign trc.full     = w_full;
   assign trc.ovfCnt   = r_ovf;
endmodule

// File: tb/tb_bus_trace_monitor.sv
// tb_bus_trace_monitor: scoreboard bench driving one bus into a drop-mode writes-only tracer (a)
// and a wrap-mode windowed tracer (b); the drain monitor pops expected entries from per-DUT queues.
module tb_bus_trace_monitor;
   localparam int TS_W  = 16;
   localparam int ENT_W = `ifdef TRACE_TIMESTAMP_EN TS_W + `endif 68;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        trace_en = 1'b1, clr = 1'b0, en = 1'b0, we = 1'b0, ready = 1'b0;
   logic [2:0]  strb = 3'b0;
   logic [31:0] addr = '0, wdata = '0, rdata = '0;
   logic [67:0] qa[$], qb[$];
   int          n_cmp = 0, n_err = 0;

   bus_trace_monitor_if #(.DEPTH(16), .TS_W(TS_W)) ia ();
   bus_trace_monitor_if #(.DEPTH(16), .TS_W(TS_W)) ib ();

   bus_trace_monitor #(.DEPTH(16), .MODE(1), .WRAP(0), .TS_W(TS_W)) dut_a (
      .clk(clk), .reset(reset), .trc(ia.slave));
   bus_trace_monitor #(.DEPTH(16), .MODE(0), .WRAP(1), .TS_W(TS_W),
                       .WIN_BASE(32'h1000_0000), .WIN_MASK(32'hF000_0000)) dut_b (
      .clk(clk), .reset(reset), .trc(ib.slave));

   assign {ia.traceEn, ia.trcClr, ia.busEn, ia.busWe, ia.strb} = {trace_en, clr, en, we, strb};
   assign {ib.traceEn, ib.trcClr, ib.busEn, ib.busWe, ib.strb} = {trace_en, clr, en, we, strb};
   assign {ia.busAddr, ia.busWData, ia.busRData, ia.trcReady} = {addr, wdata, rdata, ready};
   assign {ib.busAddr, ib.busWData, ib.busRData, ib.trcReady} = {addr, wdata, rdata, ready};

   always #5 clk = ~clk;

   // Drain-side scoreboard: every accepted head entry must match the oldest expectation.
   always @(negedge clk) begin
      if (ia.trcValid && ia.trcReady) begin
         n_cmp++;
         if (qa.size() == 0) begin
            n_err++;
            $display("FAIL a_pop_unexpected got=%h expected=none", ia.trcData[67:0]);
         end else if (ia.trcData[67:0] !== qa[0]) begin
            n_err++;
            $display("FAIL a_pop got=%h expected=%h", ia.trcData[67:0], qa[0]);
         end
         if (qa.size() != 0) void'(qa.pop_front());
      end
      if (ib.trcValid && ib.trcReady) begin
         n_cmp++;
         if (qb.size() == 0) begin
            n_err++;
            $display("FAIL b_pop_unexpected got=%h expected=none", ib.trcData[67:0]);
         end else if (ib.trcData[67:0] !== qb[0]) begin
            n_err++;
            $display("FAIL b_pop got=%h expected=%h", ib.trcData[67:0], qb[0]);
         end
         if (qb.size() != 0) void'(qb.pop_front());
      end
   end

   function automatic logic [67:0] ent(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
      return {w, s, a, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
      en = 1'b1; we = w; strb = s; addr = a;
      if (w) wdata = d; else rdata = d;
      cyc();
      en = 1'b0;
   endtask

   task automatic drain();
      ready = 1'b1;
      for (int i = 0; i < 64 && (ia.trcCount != 0 || ib.trcCount != 0); i++) cyc();
      ready = 1'b0;
      chk("drain_a_left", qa.size(), 0);
      chk("drain_b_left", qb.size(), 0);
      chk("drain_a_cnt", 32'(ia.trcCount), 0);
      chk("drain_b_cnt", 32'(ib.trcCount), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_valid", 32'(ia.trcValid), 0);
      chk("rst_a_cnt",   32'(ia.trcCount), 0);
      chk("rst_a_full",  32'(ia.full), 0);
      chk("rst_a_ovf",   32'(ia.ovfCnt), 0);
      chk("rst_b_valid", 32'(ib.trcValid), 0);
      chk("rst_b_ovf",   32'(ib.ovfCnt), 0);
      reset = 1'b1;
      cyc();

      access(1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
      qa.push_back(ent(1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF));
      qb.push_back(ent(1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF));
      chk("wr_a_valid", 32'(ia.trcValid), 1);
      chk("wr_a_data_lo", ia.trcData[31:0], 32'hDEAD_BEEF);
      chk("wr_a_addr", ia.trcData[63:32], 32'h1000_0004);
      chk("wr_b_cnt", 32'(ib.trcCount), 1);
      drain();

      access(1'b0, 3'b010, 32'h2000_0000, 32'h1234_5678);
      chk("rd_out_a_cnt", 32'(ia.trcCount), 0);
      chk("rd_out_b_cnt", 32'(ib.trcCount), 0);
      access(1'b0, 3'b100, 32'h1000_0008, 32'hCAFE_F00D);
      qb.push_back(ent(1'b0, 3'b100, 32'h1000_0008, 32'hCAFE_F00D));
      chk("rd_in_a_cnt", 32'(ia.trcCount), 0);
      chk("rd_in_b_cnt", 32'(ib.trcCount), 1);
      trace_en = 1'b0;
      access(1'b1, 3'b010, 32'h1000_000C, 32'h5555_AAAA);
      trace_en = 1'b1;
      chk("dis_a_cnt", 32'(ia.trcCount), 0);
      chk("dis_b_cnt", 32'(ib.trcCount), 1);
      drain();

      for (int i = 0; i < 18; i++) begin
         access(1'b1, 3'b010, 32'h1000_0000 + 32'(4 * i), 32'(i));
         if (i < 16) qa.push_back(ent(1'b1, 3'b010, 32'h1000_0000 + 32'(4 * i), 32'(i)));
         if (i >= 2) qb.push_back(ent(1'b1, 3'b010, 32'h1000_0000 + 32'(4 * i), 32'(i)));
      end
      chk("ovf_a_full", 32'(ia.full), 1);
      chk("ovf_a_cnt",  32'(ia.trcCount), 16);
      chk("ovf_a_ovf",  32'(ia.ovfCnt), 2);
      chk("ovf_b_full", 32'(ib.full), 1);
      chk("ovf_b_cnt",  32'(ib.trcCount), 16);
      chk("ovf_b_ovf",  32'(ib.ovfCnt), 2);

      ready = 1'b1;
      access(1'b1, 3'b010, 32'h1000_00F0, 32'd100);
      ready = 1'b0;
      qa.push_back(ent(1'b1, 3'b010, 32'h1000_00F0, 32'd100));
      qb.push_back(ent(1'b1, 3'b010, 32'h1000_00F0, 32'd100));
      chk("pp_a_cnt", 32'(ia.trcCount), 16);
      chk("pp_a_ovf", 32'(ia.ovfCnt), 2);
      chk("pp_b_cnt", 32'(ib.trcCount), 16);
      chk("pp_b_ovf", 32'(ib.ovfCnt), 2);
      drain();
      chk("drain_a_full", 32'(ia.full), 0);

      access(1'b1, 3'b010, 32'h1000_0010, 32'd1);
      access(1'b1, 3'b010, 32'h1000_0014, 32'd2);
      chk("preclr_a_cnt", 32'(ia.trcCount), 2);
      clr = 1'b1;
      access(1'b1, 3'b010, 32'h1000_0018, 32'd3);
      clr = 1'b0;
      chk("clr_a_cnt",   32'(ia.trcCount), 0);
      chk("clr_a_valid", 32'(ia.trcValid), 0);
      chk("clr_a_ovf",   32'(ia.ovfCnt), 0);
      chk("clr_b_cnt",   32'(ib.trcCount), 0);
      chk("clr_b_ovf",   32'(ib.ovfCnt), 0);
      access(1'b1, 3'b000, 32'h1000_0020, 32'h77);
      qa.push_back(ent(1'b1, 3'b000, 32'h1000_0020, 32'h77));
      qb.push_back(ent(1'b1, 3'b000, 32'h1000_0020, 32'h77));
      chk("postclr_a_cnt", 32'(ia.trcCount), 1);
      drain();

`ifdef TRACE_TIMESTAMP_EN
      begin
         logic [TS_W-1:0] t1;
         access(1'b1, 3'b010, 32'h1000_0030, 32'hA1);
         repeat (3) cyc();
         access(1'b1, 3'b010, 32'h1000_0034, 32'hA2);
         qa.push_back(ent(1'b1, 3'b010, 32'h1000_0030, 32'hA1));
         qa.push_back(ent(1'b1, 3'b010, 32'h1000_0034, 32'hA2));
         qb.push_back(ent(1'b1, 3'b010, 32'h1000_0030, 32'hA1));
         qb.push_back(ent(1'b1, 3'b010, 32'h1000_0034, 32'hA2));
         t1 = ia.trcData[ENT_W-1 -: TS_W];
         ready = 1'b1;
         cyc();
         ready = 1'b0;
         chk("ts_delta", 32'(ia.trcData[ENT_W-1 -: TS_W] - t1), 4);
         drain();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
